// File: rtl/permute_engine.sv
// Keccak-style step-mapping engine: loads LINES 25-bit slices from a synchronous
// line memory, applies copy/theta/rho/pi, and writes the result back in place.
module permute_engine #(
    parameter int LINES = 64,
    parameter int AW    = $clog2(LINES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    output logic          busy,
    output logic          finish,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [24:0]   rd_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [24:0]   wr_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(LINES - 1);

    // Rotation offsets indexed by bit position i = x + 5y.
    localparam logic [5:0] RHO [25] = '{
        6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
        6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
        6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
        6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
        6'd18, 6'd2,  6'd61, 6'd56, 6'd14
    };

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [1:0]    mode_q, mode_d;
    logic [24:0]   buf_q [LINES];

    logic          buf_we;
    logic [AW-1:0] buf_wa;
    logic [AW-1:0] prv_idx;
    logic [24:0]   rho_w;
    logic [24:0]   map_w;

    function automatic logic [24:0] theta_f(input logic [24:0] cur, input logic [24:0] prv);
        logic [4:0]  pc;
        logic [4:0]  pp;
        logic [24:0] r;
        for (int x = 0; x < 5; x++) begin
            pc[x] = cur[x] ^ cur[x+5] ^ cur[x+10] ^ cur[x+15] ^ cur[x+20];
            pp[x] = prv[x] ^ prv[x+5] ^ prv[x+10] ^ prv[x+15] ^ prv[x+20];
        end
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                r[x+5*y] = cur[x+5*y] ^ pc[(x+4)%5] ^ pp[(x+1)%5];
            end
        end
        return r;
    endfunction

    function automatic logic [24:0] pi_f(input logic [24:0] a);
        logic [24:0] r;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                r[x+5*y] = a[(x+3*y)%5 + 5*x];
            end
        end
        return r;
    endfunction

    assign prv_idx = cnt_q - 1'b1;

    // Each lane of the output slice pulls from its own rotated source slice.
    always_comb begin
        rho_w = '0;
        for (int i = 0; i < 25; i++) begin
            rho_w[i] = buf_q[cnt_q - RHO[i][AW-1:0]][i];
        end
    end

    always_comb begin
        map_w = buf_q[cnt_q];
        case (mode_q)
            2'b01:   map_w = theta_f(buf_q[cnt_q], buf_q[prv_idx]);
            2'b10:   map_w = rho_w;
            2'b11:   map_w = pi_f(buf_q[cnt_q]);
            default: map_w = buf_q[cnt_q];
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        busy    = (state_q != S_IDLE);
        finish  = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        buf_we  = 1'b0;
        buf_wa  = prv_idx;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    mode_d  = mode;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                rd_en   = 1'b1;
                rd_addr = cnt_q;
                // Read data lags the strobe by one cycle, so address 0 has nothing to store yet.
                buf_we  = (cnt_q != '0);
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                buf_we  = 1'b1;
                buf_wa  = LAST;
                state_d = S_WRITE;
                cnt_d   = '0;
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                wr_data = map_w;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) begin
                buf_q[i] <= '0;
            end
        end else if (buf_we) begin
            buf_q[buf_wa] <= rd_data;
        end
    end

endmodule

// File: tb/tb_permute_engine.sv
// Bench for permute_engine: two instances (64 and 16 slices) on behavioural
// memories, checked against a lane/slice-level Keccak step model.
module tb_permute_engine;

    localparam int NA = 64;
    localparam int NB = 16;

    typedef logic [24:0] state_t [64];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [1:0] mode;
    int         sel;
    logic       pl_go;
    state_t     pl_img;

    int ntests = 0;
    int nfail  = 0;
    int roff [25];

    logic        start_a, start_b;
    logic        busy_a, finish_a, rd_en_a, wr_en_a;
    logic [5:0]  rd_addr_a, wr_addr_a;
    logic [24:0] rd_data_a, wr_data_a;
    logic        busy_b, finish_b, rd_en_b, wr_en_b;
    logic [3:0]  rd_addr_b, wr_addr_b;
    logic [24:0] rd_data_b, wr_data_b;

    logic [24:0] mem_a [64];
    logic [24:0] mem_b [16];

    assign start_a = (sel == 0) ? start : 1'b0;
    assign start_b = (sel == 1) ? start : 1'b0;

    permute_engine #(.LINES(NA)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode),
        .busy(busy_a), .finish(finish_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a)
    );

    permute_engine #(.LINES(NB)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode),
        .busy(busy_b), .finish(finish_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
    );

    logic       v_busy, v_finish, v_rd_en, v_wr_en;
    logic [5:0] v_rd_addr, v_wr_addr;
    assign v_busy    = sel ? busy_b   : busy_a;
    assign v_finish  = sel ? finish_b : finish_a;
    assign v_rd_en   = sel ? rd_en_b  : rd_en_a;
    assign v_wr_en   = sel ? wr_en_b  : wr_en_a;
    assign v_rd_addr = sel ? {2'b00, rd_addr_b} : rd_addr_a;
    assign v_wr_addr = sel ? {2'b00, wr_addr_b} : wr_addr_a;

    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
        if (wr_en_a) mem_a[wr_addr_a] <= wr_data_a;
        if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
        if (wr_en_b) mem_b[wr_addr_b] <= wr_data_b;
        if (pl_go) begin
            for (int i = 0; i < 64; i++) begin
                if (sel == 0) mem_a[i] <= pl_img[i];
                else if (i < 16) mem_b[i] <= pl_img[i];
            end
        end
    end

    function automatic logic [24:0] get_mem(input int z);
        return (sel == 0) ? mem_a[z] : mem_b[z % 16];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offsets from the lane walk (x,y) -> (y, 2x+3y), r = (t+1)(t+2)/2.
    task automatic build_rho;
        int x, y, nx;
        x = 1; y = 0;
        roff[0] = 0;
        for (int t = 0; t < 24; t++) begin
            roff[x + 5*y] = ((t + 1) * (t + 2)) / 2;
            nx = y;
            y  = (2*x + 3*y) % 5;
            x  = nx;
        end
    endtask

    task automatic model(input state_t s, input int n, input int md, output state_t r);
        bit c [5][64];
        r = s;
        case (md)
            1: begin
                for (int z = 0; z < n; z++)
                    for (int x = 0; x < 5; x++) begin
                        c[x][z] = 1'b0;
                        for (int y = 0; y < 5; y++) c[x][z] = c[x][z] ^ s[z][x + 5*y];
                    end
                for (int z = 0; z < n; z++)
                    for (int x = 0; x < 5; x++)
                        for (int y = 0; y < 5; y++)
                            r[z][x + 5*y] = s[z][x + 5*y] ^ c[(x+4)%5][z] ^ c[(x+1)%5][(z+n-1)%n];
            end
            2: begin
                for (int z = 0; z < n; z++)
                    for (int i = 0; i < 25; i++)
                        r[z][i] = s[(z - (roff[i] % n) + n) % n][i];
            end
            3: begin
                for (int z = 0; z < n; z++)
                    for (int x = 0; x < 5; x++)
                        for (int y = 0; y < 5; y++)
                            r[z][x + 5*y] = s[z][(x + 3*y) % 5 + 5*x];
            end
            default: r = s;
        endcase
    endtask

    task automatic rand_state(output state_t s);
        logic [31:0] t;
        for (int i = 0; i < 64; i++) begin
            t = $urandom;
            s[i] = t[24:0];
        end
    endtask

    task automatic preload(input state_t s);
        pl_img = s;
        pl_go = 1'b1;
        @(negedge clk);
        pl_go = 1'b0;
    endtask

    task automatic launch(input logic [1:0] md);
        logic [31:0] t;
        start = 1'b1;
        mode  = md;
        @(negedge clk);
        t = $urandom;
        start = 1'b0;
        mode  = t[1:0];
    endtask

    // Entered at the negedge of the first LOAD cycle; returns in the finish cycle
    // (or the reset cycle when rst_at is reached).
    task automatic monitor(input int n, input int poke_at, input int rst_at, input bit chain,
                           input logic [1:0] md2, output int lat, output bit ab);
        int cyc, rdc, wrc;
        bit done;
        cyc = 1; rdc = 0; wrc = 0; done = 0; lat = -1; ab = 0;
        while (!done && cyc < 4*n + 20) begin
            start = (cyc == poke_at);
            check("busy_active", 32'(v_busy), 1);
            check("rd_wr_excl", 32'(v_rd_en & v_wr_en), 0);
            if (v_rd_en) begin
                check("rd_addr", 32'(v_rd_addr), rdc);
                rdc++;
            end
            if (v_wr_en) begin
                check("reads_before_write", rdc, n);
                check("wr_addr", 32'(v_wr_addr), wrc);
                wrc++;
            end
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_wr_en", 32'(v_wr_en), 0);
                check("rst_rd_en", 32'(v_rd_en), 0);
                check("rst_busy", 32'(v_busy), 0);
                check("rst_finish", 32'(v_finish), 0);
                ab = 1; done = 1;
            end else if (v_finish) begin
                lat = cyc;
                done = 1;
                check("write_count", wrc, n);
                if (chain) begin
                    start = 1'b1;
                    mode  = ~md2;
                end
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = chain && !ab && (lat >= 0);
    endtask

    task automatic cmp_mem(input string tag, input state_t e, input int n);
        for (int z = 0; z < n; z++)
            check($sformatf("%s[%0d]", tag, z), 32'(get_mem(z)), 32'(e[z]));
    endtask

    task automatic idle_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(v_busy), 0);
            check("idle_rd_en", 32'(v_rd_en), 0);
            check("idle_wr_en", 32'(v_wr_en), 0);
        end
    endtask

    task automatic do_run(input logic [1:0] md, input state_t init, input int poke_at, output state_t e);
        int n, lat;
        bit ab;
        n = (sel == 0) ? NA : NB;
        model(init, n, int'(md), e);
        preload(init);
        launch(md);
        monitor(n, poke_at, -1, 1'b0, 2'b00, lat, ab);
        check("latency", lat, 2*n + 2);
        cmp_mem($sformatf("mode%0d_slice", md), e, n);
        idle_check(3);
    endtask

    initial begin
        state_t init, e, e2;
        int lat;
        bit ab;
        logic [31:0] t;

        build_rho;
        rst = 1'b1; start = 1'b0; mode = 2'b00; sel = 0; pl_go = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy_a), 0);
        check("reset_finish", 32'(finish_a), 0);
        check("reset_rd_en", 32'(rd_en_a), 0);
        check("reset_wr_en", 32'(wr_en_a), 0);
        check("reset_rd_addr", 32'(rd_addr_a), 0);
        check("reset_wr_addr", 32'(wr_addr_a), 0);
        check("reset_wr_data", 32'(wr_data_a), 0);
        check("reset_busy_b", 32'(busy_b), 0);
        rst = 1'b0;
        @(negedge clk);

        // Copy with memory[z] = z.
        for (int z = 0; z < 64; z++) init[z] = 25'(z);
        do_run(2'b00, init, -1, e);

        // Theta single bit.
        for (int z = 0; z < 64; z++) init[z] = '0;
        init[5] = 25'h0000001;
        do_run(2'b01, init, -1, e);
        check("theta_slice5", 32'(get_mem(5)), 32'h0210843);
        check("theta_slice6", 32'(get_mem(6)), 32'h1084210);

        // Rho wrap from slice 63 to slice 0.
        for (int z = 0; z < 64; z++) init[z] = '0;
        init[63] = 25'h0000002;
        do_run(2'b10, init, -1, e);
        check("rho_wrap_slice0", 32'(get_mem(0)), 32'h0000002);
        check("rho_wrap_slice63", 32'(get_mem(63)), 0);

        // Pi single lane.
        for (int z = 0; z < 64; z++) init[z] = '0;
        init[0] = 25'h0000002;
        do_run(2'b11, init, -1, e);
        check("pi_slice0", 32'(get_mem(0)), 32'h0000400);

        // Random states in every mode.
        for (int k = 0; k < 8; k++) begin
            rand_state(init);
            do_run(2'(k % 4), init, -1, e);
        end

        // start pulse during WRITE is ignored.
        rand_state(init);
        do_run(2'b01, init, NA + 20, e);

        // Reset in the 10th WRITE cycle.
        rand_state(init);
        model(init, NA, 1, e);
        preload(init);
        launch(2'b01);
        monitor(NA, -1, NA + 11, 1'b0, 2'b00, lat, ab);
        check("rst_aborted", 32'(ab), 1);
        @(negedge clk);
        rst = 1'b0;
        idle_check(3);
        for (int z = 0; z < NA; z++)
            check($sformatf("rst_partial[%0d]", z), 32'(get_mem(z)), (z < 9) ? 32'(e[z]) : 32'(init[z]));
        rand_state(init);
        do_run(2'b10, init, -1, e);

        // Back-to-back with start held across DONE.
        rand_state(init);
        model(init, NA, 2, e);
        model(e, NA, 3, e2);
        preload(init);
        launch(2'b10);
        monitor(NA, -1, -1, 1'b1, 2'b11, lat, ab);
        check("b2b_lat1", lat, 2*NA + 2);
        @(negedge clk);
        check("b2b_idle_busy", 32'(v_busy), 0);
        check("b2b_idle_finish", 32'(v_finish), 0);
        mode = 2'b11;
        @(negedge clk);
        t = $urandom;
        start = 1'b0;
        mode = t[1:0];
        monitor(NA, -1, -1, 1'b0, 2'b00, lat, ab);
        check("b2b_lat2", lat, 2*NA + 2);
        cmp_mem("b2b_slice", e2, NA);
        idle_check(2);

        // 16-slice instance.
        sel = 1;
        @(negedge clk);
        for (int z = 0; z < 64; z++) init[z] = '0;
        init[0] = 25'h0000004;
        do_run(2'b10, init, -1, e);
        check("rho16_slice14", 32'(get_mem(14)), 32'h0000004);
        check("rho16_slice0", 32'(get_mem(0)), 0);
        for (int k = 0; k < 4; k++) begin
            rand_state(init);
            do_run(2'(k), init, -1, e);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
